// File: rtl/link_stall_monitor_pkg.sv
// Shared types and constants for the link stall monitor.
package link_stall_monitor_pkg;

  // Packet type code of a MESSAGE_DELIVERY header, carried in header bits [23:16].
  // Keep in step with the task injector's encoding.
  localparam logic [7:0]  MESSAGE_DELIVERY = 8'h01;

  localparam logic [31:0] STALL_CNT_MAX    = 32'hFFFF_FFFF;
  localparam logic [15:0] DROP_CNT_MAX     = 16'hFFFF;

  // Position of the flit being accepted within the current packet.
  typedef enum logic [1:0] {
    StHeader,
    StSrcpe,
    StEdge,
    StBody
  } link_mon_state_t;

  typedef struct packed {
    logic [15:0] prod;
    logic [15:0] cons;
    logic [31:0] start;
    logic [31:0] cycles;
  } link_mon_evt_t;

endpackage

// File: rtl/link_stall_monitor_if.sv
// Flit/credit link and stall event bundle seen by the link stall monitor.
// The slave modport is the monitor's view; master is the environment's view.
interface link_stall_monitor_if;
  logic        tx_i;
  logic        cr_tx_o;
  logic        eop_tx_i;
  logic [31:0] data_tx_i;
  logic        rx_o;
  logic        cr_rx_i;
  logic        eop_rx_o;
  logic [31:0] data_rx_o;
  logic        stall_o;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [15:0] evt_prod_o;
  logic [15:0] evt_cons_o;
  logic [31:0] evt_start_o;
  logic [31:0] evt_cycles_o;
  logic [15:0] evt_drop_o;

  modport slave (
    input  tx_i, eop_tx_i, data_tx_i, cr_rx_i, evt_ready_i,
    output cr_tx_o, rx_o, eop_rx_o, data_rx_o, stall_o, evt_valid_o,
           evt_prod_o, evt_cons_o, evt_start_o, evt_cycles_o, evt_drop_o
  );

  modport master (
    output tx_i, eop_tx_i, data_tx_i, cr_rx_i, evt_ready_i,
    input  cr_tx_o, rx_o, eop_rx_o, data_rx_o, stall_o, evt_valid_o,
           evt_prod_o, evt_cons_o, evt_start_o, evt_cycles_o, evt_drop_o
  );
endinterface

// File: rtl/link_stall_monitor_evt_reg.sv
// One-entry valid/ready holding register for stall event records.
// A record arriving while the entry is full and not being accepted is dropped
// and counted in a saturating drop counter.
module link_stall_monitor_evt_reg
  import link_stall_monitor_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          new_valid_i,
  input  link_mon_evt_t new_evt_i,
  input  logic          ready_i,
  output logic          valid_o,
  output link_mon_evt_t evt_o,
  output logic [15:0]   drop_o
);

  logic          r_valid;
  link_mon_evt_t r_evt;
  logic [15:0]   r_drop;
  logic          w_load;

  // The slot is free when empty or when its content is accepted this cycle.
  assign w_load = new_valid_i && (!r_valid || ready_i);

  // Entry load/accept and drop accounting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_evt   <= '0;
      r_drop  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_evt   <= new_evt_i;
    end else if (new_valid_i) begin
      if (r_drop != DROP_CNT_MAX) begin
        r_drop <= r_drop + 16'd1;
      end
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign evt_o   = r_evt;
  assign drop_o  = r_drop;

endmodule

// File: rtl/link_stall_monitor.sv
// Passive link observer: forwards the flit/credit link unchanged and reports
// in-packet stall gaps of at least STALL_THRESHOLD cycles as event records.
// Optional: define LINK_MON_LOG_EN (simulation only) to print CSV lines of
// loaded and dropped events, tagged with lm<x>x<y>-<PORT>.
module link_stall_monitor
  import link_stall_monitor_pkg::*;
#(
  parameter logic [15:0] ADDRESS         = 16'h0000,
  parameter string       PORT            = "",
  parameter int unsigned STALL_THRESHOLD = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  link_stall_monitor_if.slave link_io
);

  localparam logic [31:0] StallThr = 32'(STALL_THRESHOLD);

  link_mon_state_t r_state;
  logic [31:0]     r_stall_cnt;
  logic [31:0]     r_cycle_cnt;
  logic [15:0]     r_prod;
  logic [15:0]     r_cons;
  logic            r_stall;

  logic            w_hs;
  logic            w_in_pkt;
  logic            w_evt_new;
  link_mon_evt_t   w_evt;
  logic            w_evt_valid;
  link_mon_evt_t   w_evt_q;
  logic [15:0]     w_evt_drop;

  // ADDRESS and PORT only name the optional log output.
  logic            w_unused_params;
  assign w_unused_params = ^{ADDRESS, (PORT == "")};

  // The link itself is never touched, not even in reset.
  assign link_io.rx_o      = link_io.tx_i;
  assign link_io.eop_rx_o  = link_io.eop_tx_i;
  assign link_io.data_rx_o = link_io.data_tx_i;
  assign link_io.cr_tx_o   = link_io.cr_rx_i;

  assign w_hs      = link_io.tx_i && link_io.cr_rx_i;
  assign w_in_pkt  = (r_state != StHeader);
  assign w_evt_new = w_hs && (r_stall_cnt >= StallThr);

  // Record for a stall that ends with this handshake.
  always_comb begin
    w_evt        = '0;
    w_evt.prod   = r_prod;
    w_evt.cons   = r_cons;
    w_evt.start  = r_cycle_cnt - r_stall_cnt;
    w_evt.cycles = r_stall_cnt;
  end

  // Packet parser: tracks flit position and latches producer/consumer ids.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StHeader;
      r_prod  <= '0;
      r_cons  <= '0;
    end else if (w_hs) begin
      case (r_state)
        StHeader: begin
          r_prod <= '0;
          r_cons <= '0;
          if (link_io.data_tx_i[23:16] == MESSAGE_DELIVERY) begin
            r_state <= StSrcpe;
          end else begin
            r_state <= StBody;
          end
        end
        StSrcpe: r_state <= StEdge;
        StEdge: begin
          r_prod  <= link_io.data_tx_i[31:16];
          r_cons  <= link_io.data_tx_i[15:0];
          r_state <= StBody;
        end
        StBody:  r_state <= StBody;
        default: r_state <= StHeader;
      endcase
      // End of packet wins over any positional transition.
      if (link_io.eop_tx_i) begin
        r_state <= StHeader;
      end
    end
  end

  // Free-running cycle stamp, in-packet stall length and registered stall flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_stall     <= 1'b0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      r_stall     <= w_in_pkt && (r_stall_cnt >= StallThr);
      if (w_hs) begin
        r_stall_cnt <= '0;
      end else if (w_in_pkt && (r_stall_cnt != STALL_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  link_stall_monitor_evt_reg u_evt_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .new_valid_i (w_evt_new),
    .new_evt_i   (w_evt),
    .ready_i     (link_io.evt_ready_i),
    .valid_o     (w_evt_valid),
    .evt_o       (w_evt_q),
    .drop_o      (w_evt_drop)
  );

  assign link_io.stall_o      = r_stall;
  assign link_io.evt_valid_o  = w_evt_valid;
  assign link_io.evt_prod_o   = w_evt_q.prod;
  assign link_io.evt_cons_o   = w_evt_q.cons;
  assign link_io.evt_start_o  = w_evt_q.start;
  assign link_io.evt_cycles_o = w_evt_q.cycles;
  assign link_io.evt_drop_o   = w_evt_drop;

`ifdef LINK_MON_LOG_EN
  string log_name;

  // Name the per-link log and print the CSV header.
  initial begin
    log_name = $sformatf("lm%0dx%0d-%s", ADDRESS[15:8], ADDRESS[7:0], PORT);
    $display("%s: start,end,prod,cons,cycles", log_name);
  end

  // One line per record loaded into the event register, one per drop.
  always @(posedge clk_i) begin
    if (!rst_i && w_evt_new) begin
      if (!w_evt_valid || link_io.evt_ready_i) begin
        $display("%s: %0d,%0d,%0d,%0d,%0d", log_name, w_evt.start, r_cycle_cnt, w_evt.prod,
                 w_evt.cons, w_evt.cycles);
      end else begin
        $display("%s: drop,%0d", log_name, r_cycle_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_link_stall_monitor.sv
// Self-checking bench for link_stall_monitor with a packet-level reference model.
module tb_link_stall_monitor;
  import link_stall_monitor_pkg::*;

  localparam int unsigned Thr = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  link_stall_monitor_if u_if ();

  link_stall_monitor #(
    .ADDRESS         (16'h0203),
    .PORT            ("east"),
    .STALL_THRESHOLD (Thr)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .link_io (u_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Values currently driven onto the link.
  bit          d_tx, d_eop, d_cr, d_rdy;
  logic [31:0] d_data;

  // Reference model: packet position, gap length, one-slot event store.
  bit          m_in_pkt, m_deliv, m_stall, m_q_valid;
  int unsigned m_idx;
  logic [31:0] m_gap, m_cyc, m_q_start, m_q_cycles;
  logic [15:0] m_prod, m_cons, m_drop, m_q_prod, m_q_cons;

  function automatic logic [113:0] obs();
    return {u_if.evt_valid_o, u_if.stall_o, u_if.evt_drop_o, u_if.evt_prod_o, u_if.evt_cons_o,
            u_if.evt_start_o, u_if.evt_cycles_o};
  endfunction

  function automatic logic [113:0] mdl();
    return {m_q_valid, m_stall, m_drop, m_q_prod, m_q_cons, m_q_start, m_q_cycles};
  endfunction

  function automatic void model_reset();
    m_in_pkt = 1'b0; m_deliv = 1'b0; m_stall = 1'b0; m_q_valid = 1'b0; m_idx = 0;
    m_gap = '0; m_cyc = '0; m_q_start = '0; m_q_cycles = '0;
    m_prod = '0; m_cons = '0; m_drop = '0; m_q_prod = '0; m_q_cons = '0;
  endfunction

  function automatic void model_step();
    bit hs;
    bit new_evt;
    hs      = d_tx && d_cr;
    new_evt = hs && (m_gap >= Thr);
    m_stall = m_in_pkt && (m_gap >= Thr);
    if (new_evt) begin
      if (!m_q_valid || d_rdy) begin
        m_q_valid = 1'b1; m_q_prod = m_prod; m_q_cons = m_cons;
        m_q_start = m_cyc - m_gap; m_q_cycles = m_gap;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end else if (d_rdy) begin
      m_q_valid = 1'b0;
    end
    if (hs) begin
      if (!m_in_pkt) begin
        m_prod = '0; m_cons = '0;
        m_deliv  = (d_data[23:16] == MESSAGE_DELIVERY);
        m_idx    = 1;
        m_in_pkt = !d_eop;
      end else begin
        // Third flit of a delivery packet carries producer/consumer.
        if (m_deliv && m_idx == 2) {m_prod, m_cons} = d_data;
        m_idx = m_idx + 1;
        if (d_eop) m_in_pkt = 1'b0;
      end
      m_gap = '0;
    end else if (m_in_pkt && m_gap != 32'hFFFF_FFFF) begin
      m_gap = m_gap + 32'd1;
    end
    m_cyc = m_cyc + 32'd1;
  endfunction

  task automatic drive(input bit tx, input bit eop, input logic [31:0] data, input bit cr,
                       input bit rdy);
    d_tx = tx; d_eop = eop; d_data = data; d_cr = cr; d_rdy = rdy;
    u_if.tx_i = tx; u_if.eop_tx_i = eop; u_if.data_tx_i = data;
    u_if.cr_rx_i = cr; u_if.evt_ready_i = rdy;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle(input int unsigned n, input bit rdy);
    for (int unsigned k = 0; k < n; k++) drive(1'b0, 1'b0, $urandom(), 1'b1, rdy);
  endtask

  // Header, source PE, edge, timestamp of a delivery packet.
  task automatic deliv_head(input logic [31:0] edge_w);
    drive(1'b1, 1'b0, {8'h11, MESSAGE_DELIVERY, 16'h2233}, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0000_0005, 1'b1, 1'b0);
    drive(1'b1, 1'b0, edge_w, 1'b1, 1'b0);
    drive(1'b1, 1'b0, $urandom(), 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    n_cmp++;
    if ({u_if.rx_o, u_if.eop_rx_o, u_if.data_rx_o, u_if.cr_tx_o} !==
        {1'b1, 1'b0, 32'h1234_5678, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_passthru: got %h/%h/%h/%h want 1/0/12345678/0", u_if.rx_o,
               u_if.eop_rx_o, u_if.data_rx_o, u_if.cr_tx_o);
    end
    n_cmp++;
    if (obs() !== 114'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want 0", obs());
    end
    rst = 1'b0;
  endtask

  task automatic test_no_stall();
    logic [31:0] f [6];
    f[0] = {8'h11, MESSAGE_DELIVERY, 16'h2233}; f[1] = 32'h0000_0005; f[2] = 32'h0102_0304;
    f[3] = $urandom(); f[4] = $urandom(); f[5] = $urandom();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 5), f[i], 1'b1, 1'b0);
      n_cmp++;
      if ({u_if.evt_valid_o, u_if.stall_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL nostall_quiet[%0d]: got %b%b want 00", i, u_if.evt_valid_o, u_if.stall_o);
      end
      n_cmp++;
      if ({u_if.rx_o, u_if.eop_rx_o, u_if.data_rx_o} !== {1'b1, (i == 5), f[i]}) begin
        n_fail++;
        $display("FAIL nostall_passthru[%0d]: got %h want %h", i, u_if.data_rx_o, f[i]);
      end
    end
  endtask

  task automatic test_stall_gap();
    logic [31:0] stamp;
    deliv_head(32'h0102_0304);
    stamp = m_cyc;
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b0, $urandom(), 1'b1, 1'b0);
      if (k == 16 || k == 17) begin
        n_cmp++;
        if (u_if.stall_o !== (k == 17)) begin
          n_fail++;
          $display("FAIL stall_rise@%0d: got %b want %b", k, u_if.stall_o, (k == 17));
        end
      end
    end
    drive(1'b1, 1'b0, $urandom(), 1'b1, 1'b0);
    n_cmp++;
    if ({u_if.evt_valid_o, u_if.evt_prod_o, u_if.evt_cons_o, u_if.evt_cycles_o,
         u_if.evt_start_o} !== {1'b1, 16'h0102, 16'h0304, 32'd20, stamp}) begin
      n_fail++;
      $display("FAIL stall_event: got %b %h %h %0d %0d want 1 0102 0304 20 %0d",
               u_if.evt_valid_o, u_if.evt_prod_o, u_if.evt_cons_o, u_if.evt_cycles_o,
               u_if.evt_start_o, stamp);
    end
    drive(1'b1, 1'b1, $urandom(), 1'b1, 1'b1);
    n_cmp++;
    if (u_if.evt_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_accept: got %b want 0", u_if.evt_valid_o);
    end
  endtask

  task automatic test_short_gap();
    deliv_head($urandom());
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, $urandom(), 1'b1, 1'b0);
      n_cmp++;
      if (u_if.stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL short_stall[%0d]: got %b want 0", k, u_if.stall_o);
      end
    end
    drive(1'b1, 1'b1, $urandom(), 1'b1, 1'b0);
    n_cmp++;
    if (u_if.evt_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL short_event: got %b want 0", u_if.evt_valid_o);
    end
  endtask

  task automatic test_drop();
    logic [31:0] stamp;
    deliv_head(32'hCAFE_0042);
    stamp = m_cyc;
    idle(20, 1'b0);
    drive(1'b1, 1'b0, $urandom(), 1'b1, 1'b0);
    idle(20, 1'b0);
    drive(1'b1, 1'b1, $urandom(), 1'b1, 1'b0);
    n_cmp++;
    if ({u_if.evt_valid_o, u_if.evt_cycles_o, u_if.evt_start_o, u_if.evt_drop_o} !==
        {1'b1, 32'd20, stamp, 16'd1}) begin
      n_fail++;
      $display("FAIL drop_hold: got %b %0d %0d %0d want 1 20 %0d 1", u_if.evt_valid_o,
               u_if.evt_cycles_o, u_if.evt_start_o, u_if.evt_drop_o, stamp);
    end
    idle(1, 1'b1);
    n_cmp++;
    if (u_if.evt_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_accept: got %b want 0", u_if.evt_valid_o);
    end
  endtask

  task automatic test_non_delivery();
    drive(1'b1, 1'b0, {8'h11, MESSAGE_DELIVERY ^ 8'h80, 16'h2233}, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h0506_0708, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h090A_0B0C, 1'b1, 1'b0);
    idle(20, 1'b0);
    drive(1'b1, 1'b1, $urandom(), 1'b1, 1'b0);
    n_cmp++;
    if ({u_if.evt_valid_o, u_if.evt_prod_o, u_if.evt_cons_o, u_if.evt_cycles_o} !==
        {1'b1, 16'h0, 16'h0, 32'd20}) begin
      n_fail++;
      $display("FAIL nondeliv_event: got %b %h %h %0d want 1 0000 0000 20", u_if.evt_valid_o,
               u_if.evt_prod_o, u_if.evt_cons_o, u_if.evt_cycles_o);
    end
    idle(1, 1'b1);
    for (int k = 0; k < 30; k++) begin
      drive(1'b0, 1'b0, $urandom(), 1'b1, 1'b0);
      n_cmp++;
      if ({u_if.evt_valid_o, u_if.stall_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL nondeliv_idle[%0d]: got %b%b want 00", k, u_if.evt_valid_o,
                 u_if.stall_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    deliv_head($urandom());
    idle(20, 1'b0);
    drive(1'b1, 1'b0, $urandom(), 1'b1, 1'b0);
    idle(20, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, $urandom(), 1'b1, 1'b0);
    rst = 1'b0;
    n_cmp++;
    if (obs() !== 114'd0) begin
      n_fail++;
      $display("FAIL rstmid_state: got %h want 0", obs());
    end
    idle(20, 1'b0);
    n_cmp++;
    if (u_if.stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_header_idle: got %b want 0", u_if.stall_o);
    end
    deliv_head(32'hAAAA_BBBB);
    idle(20, 1'b0);
    drive(1'b1, 1'b1, $urandom(), 1'b1, 1'b0);
    n_cmp++;
    if ({u_if.evt_valid_o, u_if.evt_prod_o, u_if.evt_cons_o} !== {1'b1, 16'hAAAA, 16'hBBBB})
    begin
      n_fail++;
      $display("FAIL rstmid_resync: got %b %h %h want 1 aaaa bbbb", u_if.evt_valid_o,
               u_if.evt_prod_o, u_if.evt_cons_o);
    end
    idle(1, 1'b1);
  endtask

  task automatic test_random();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int p = 0; p < 60; p++) begin
      int unsigned len = $urandom_range(1, 8);
      for (int unsigned i = 0; i < len; i++) begin
        logic [31:0] w   = $urandom();
        int unsigned gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : 0;
        int unsigned tries = 0;
        bit cr;
        if (i == 0) w[23:16] = ($urandom_range(0, 1) != 0) ? MESSAGE_DELIVERY : 8'h5A;
        for (int unsigned g = 0; g < gap; g++) begin
          drive(1'b0, 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0));
          n_cmp++;
          if (obs() !== mdl()) begin
            n_fail++;
            $display("FAIL rand_gap p%0d f%0d: got %h want %h", p, i, obs(), mdl());
          end
        end
        do begin
          cr = (tries >= 4) || ($urandom_range(0, 4) != 0);
          drive(1'b1, (i == len - 1), w, cr, ($urandom_range(0, 3) == 0));
          n_cmp++;
          if (obs() !== mdl()) begin
            n_fail++;
            $display("FAIL rand_flit p%0d f%0d: got %h want %h", p, i, obs(), mdl());
          end
          n_cmp++;
          if ({u_if.rx_o, u_if.eop_rx_o, u_if.data_rx_o, u_if.cr_tx_o} !==
              {1'b1, (i == len - 1), w, cr}) begin
            n_fail++;
            $display("FAIL rand_passthru p%0d f%0d: got %h want %h", p, i, u_if.data_rx_o, w);
          end
          tries++;
        end while (!cr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_stall();
    test_stall_gap();
    test_short_gap();
    test_drop();
    test_non_delivery();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
